// File: rtl/demux4_buf_pkg.sv
// Shared definitions for the demux4_buf one-to-four distributor: default width,
// select encoding (same as the 4-way source mux, s1 = MSB) and port count.
package demux4_buf_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int NPORTS    = 4;

  localparam logic [1:0] SEL_P0 = 2'b00;
  localparam logic [1:0] SEL_P1 = 2'b01;
  localparam logic [1:0] SEL_P2 = 2'b10;
  localparam logic [1:0] SEL_P3 = 2'b11;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  function automatic logic [NPORTS-1:0] sel_decode(input logic [1:0] sel);
    logic [NPORTS-1:0] hot;
    hot = '0;
    case (sel)
      SEL_P0:  hot = 4'b0001;
      SEL_P1:  hot = 4'b0010;
      SEL_P2:  hot = 4'b0100;
      SEL_P3:  hot = 4'b1000;
      default: hot = '0;
    endcase
    return hot;
  endfunction

endpackage

// File: rtl/demux4_slot.sv
// One-entry valid/ready output buffer; a load in the same cycle as a drain
// reloads the slot so a single port sustains one word per cycle.
//   state      | meaning
//   SLOT_EMPTY | no word held, valid=0, dout keeps last loaded word
//   SLOT_FULL  | word held in dout, valid=1, waiting for ready
module demux4_slot
  import demux4_buf_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] dout
);

  slot_state_e state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SLOT_EMPTY;
      dout  <= '0;
    end else begin
      case (state)
        SLOT_EMPTY: begin
          if (load) begin
            state <= SLOT_FULL;
            dout  <= din;
          end
        end
        SLOT_FULL: begin
          if (load) begin
            dout <= din;
          end else if (ready) begin
            state <= SLOT_EMPTY;
          end
        end
        default: state <= SLOT_EMPTY;
      endcase
    end
  end

  assign valid = (state == SLOT_FULL);

endmodule

// File: rtl/demux4_buf.sv
// One-to-four distributor with a 1-entry buffer per output port.
// Optional per-port transfer counters cnt0..cnt3 when DEMUX4_STATS_EN is defined.
module demux4_buf
  import demux4_buf_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
`ifdef DEMUX4_STATS_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s1,
  input  logic              s2,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  indata,
  output logic [NPORTS-1:0] out_valid,
  input  logic [NPORTS-1:0] out_ready,
  output logic [WIDTH-1:0]  out0,
  output logic [WIDTH-1:0]  out1,
  output logic [WIDTH-1:0]  out2,
  output logic [WIDTH-1:0]  out3
`ifdef DEMUX4_STATS_EN
  , output logic [CNT_W-1:0] cnt0
  , output logic [CNT_W-1:0] cnt1
  , output logic [CNT_W-1:0] cnt2
  , output logic [CNT_W-1:0] cnt3
`endif
);

  logic [1:0]        sel;
  logic              fire;
  logic [NPORTS-1:0] load;
  logic [WIDTH-1:0]  dout [NPORTS];

  assign sel = {s1, s2};
  // Only the targeted port can stall the producer; in_valid is deliberately excluded.
  assign in_ready = !out_valid[sel] || out_ready[sel];
  assign fire     = in_valid && in_ready;
  assign load     = fire ? sel_decode(sel) : '0;

  for (genvar k = 0; k < NPORTS; k++) begin : g_slot
    demux4_slot #(.WIDTH(WIDTH)) u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load[k]),
      .din   (indata),
      .ready (out_ready[k]),
      .valid (out_valid[k]),
      .dout  (dout[k])
    );
  end

  assign out0 = dout[0];
  assign out1 = dout[1];
  assign out2 = dout[2];
  assign out3 = dout[3];

`ifdef DEMUX4_STATS_EN
  logic [CNT_W-1:0] cnt [NPORTS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NPORTS; k++) cnt[k] <= '0;
    end else begin
      for (int k = 0; k < NPORTS; k++) begin
        if (out_valid[k] && out_ready[k]) cnt[k] <= cnt[k] + CNT_W'(1);
      end
    end
  end

  assign cnt0 = cnt[0];
  assign cnt1 = cnt[1];
  assign cnt2 = cnt[2];
  assign cnt3 = cnt[3];
`endif

endmodule

// File: tb/tb_demux4_buf.sv
// Scoreboard bench for demux4_buf: per-port queues of words the model says are
// buffered; a negedge monitor checks valid/ready and data against them.
module tb_demux4_buf;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         s1 = 1'b0, s2 = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] indata = '0;
  logic [3:0]   out_valid;
  logic [3:0]   out_ready = '0;
  logic [W-1:0] out0, out1, out2, out3;
  logic [W-1:0] dout_w [4];

`ifdef DEMUX4_STATS_EN
  logic [3:0] cnt0, cnt1, cnt2, cnt3;
  demux4_buf #(.WIDTH(W), .CNT_W(4)) dut (
`else
  demux4_buf #(.WIDTH(W)) dut (
`endif
    .clk(clk), .rst_n(rst_n), .s1(s1), .s2(s2),
    .in_valid(in_valid), .in_ready(in_ready), .indata(indata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out0(out0), .out1(out1), .out2(out2), .out3(out3)
`ifdef DEMUX4_STATS_EN
    , .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3)
`endif
  );

  always #5 clk = ~clk;

  assign dout_w[0] = out0;
  assign dout_w[1] = out1;
  assign dout_w[2] = out2;
  assign dout_w[3] = out3;

  int npass = 0;
  int ntot  = 0;

  // Model: q[k] holds the words port k is presenting; pend is a word accepted
  // this cycle that becomes visible after the next edge.
  logic [W-1:0] q [4][$];
  logic         pend_v = 1'b0;
  int           pend_p = 0;
  logic [W-1:0] pend_d = '0;
  logic         exp_ready = 1'b1;
  logic         mon_en = 1'b0;
  int           drains [4];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step(input logic v, input int p, input logic [W-1:0] d, input logic [3:0] ordy);
    @(posedge clk);
    #1;
    if (pend_v) begin
      q[pend_p].push_back(pend_d);
      pend_v = 1'b0;
    end
    in_valid  = v;
    {s1, s2}  = 2'(p);
    indata    = d;
    out_ready = ordy;
    exp_ready = (q[p].size() == 0) || ordy[p];
    if (v && exp_ready) begin
      pend_v = 1'b1;
      pend_p = p;
      pend_d = d;
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 4; k++) begin
      q[k].delete();
      drains[k] = 0;
    end
    pend_v    = 1'b0;
    exp_ready = 1'b1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("in_ready", {31'b0, in_ready}, {31'b0, exp_ready});
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("out_valid[%0d]", k), {31'b0, out_valid[k]}, {31'b0, (q[k].size() != 0)});
        if (q[k].size() != 0) begin
          chk($sformatf("out%0d", k), dout_w[k], q[k][0]);
          if (out_ready[k]) begin
            void'(q[k].pop_front());
            drains[k]++;
          end
        end
      end
    end
  end

  initial begin
    model_clear();
    // Reset held with a word offered: nothing may be captured.
    in_valid = 1'b1; {s1, s2} = 2'b10; indata = 32'h12345678;
    repeat (3) begin
      @(negedge clk);
      chk("rst out_valid", {28'b0, out_valid}, 32'h0);
      chk("rst out0", out0, 32'h0);
      chk("rst out3", out3, 32'h0);
      chk("rst in_ready", {31'b0, in_ready}, 32'h1);
    end
    in_valid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    mon_en = 1'b1;

    // Single word to port 2, then stalled for 5 cycles, then a blocked second word.
    step(1'b1, 2, 32'hDEADBEEF, 4'b0000);
    repeat (5) step(1'b0, 2, 32'h0, 4'b0000);
    step(1'b1, 2, 32'hCAFEF00D, 4'b0000);
    // Port 2 stalled; port 1 must still accept.
    step(1'b1, 1, 32'h1, 4'b0000);
    step(1'b0, 0, 32'h0, 4'b0000);
    @(negedge clk);
    chk("nonblock out_valid", {28'b0, out_valid}, 32'h6);
    step(1'b0, 0, 32'h0, 4'b1111);
    step(1'b0, 0, 32'h0, 4'b1111);

    // Back-to-back streaming to port 0.
    for (int i = 1; i <= 8; i++) step(1'b1, 0, W'(i), 4'b0001);
    step(1'b0, 0, 32'h0, 4'b0001);
    step(1'b0, 0, 32'h0, 4'b0001);

    // Randomized traffic.
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), W'($urandom), 4'($urandom));
    step(1'b0, 0, 32'h0, 4'b1111);
    step(1'b0, 0, 32'h0, 4'b1111);

    // Asynchronous reset between edges with ports 0 and 3 full.
    step(1'b1, 0, 32'hA0A0A0A0, 4'b0000);
    step(1'b1, 3, 32'hB3B3B3B3, 4'b0000);
    step(1'b0, 0, 32'h0, 4'b0000);
    @(negedge clk);
    chk("pre-rst out_valid", {28'b0, out_valid}, 32'h9);
    #2;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk("async rst out_valid", {28'b0, out_valid}, 32'h0);
    chk("async rst out0", out0, 32'h0);
    model_clear();
    @(posedge clk); #1 rst_n = 1'b1;
    mon_en = 1'b1;

`ifdef DEMUX4_STATS_EN
    for (int i = 0; i < 17; i++) step(1'b1, 3, W'(i + 100), 4'b1000);
    step(1'b0, 0, 32'h0, 4'b1000);
    step(1'b0, 0, 32'h0, 4'b1000);
    @(negedge clk);
    chk("drains3", drains[3], 17);
    chk("cnt3", {28'b0, cnt3}, W'(drains[3] % 16));
    chk("cnt0", {28'b0, cnt0}, 32'h0);
    chk("cnt1", {28'b0, cnt1}, 32'h0);
    chk("cnt2", {28'b0, cnt2}, 32'h0);
`endif

    step(1'b0, 0, 32'h0, 4'b0000);
    @(negedge clk);
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
